// File: rtl/timer_sched.sv
// Interval sequencer: buffers up to DEPTH values and issues each to a timer, waiting for done between issues.
// Optional periodic re-issue of the last interval is enabled by defining TIMER_SCHED_REPEAT_EN.
module timer_sched #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [W-1:0]               in_value,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       cancel,
   input  logic                       done,
`ifdef TIMER_SCHED_REPEAT_EN
   input  logic                       repeat_en,
`endif
   output logic [W-1:0]               out_value,
   output logic                       out_put,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_e;

   state_e         state_q;
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [W-1:0]   out_value_q;
   logic           out_put_q;
   logic           busy_q;
   logic [W-1:0]   mem_q [DEPTH];

   logic           push, pop, rearm;

   // No bypass: a full FIFO refuses input even when a pop happens on the same edge.
   assign in_ready = (count_q != CW'(DEPTH));
   assign push     = in_valid && in_ready;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
      pop   = 1'b0;
      rearm = 1'b0;
      case (state_q)
         S_IDLE: pop = (count_q != '0);
         S_WAIT: begin
            if (done) begin
               pop = (count_q != '0);
`ifdef TIMER_SCHED_REPEAT_EN
               rearm = (count_q == '0) && repeat_en;
`endif
            end
         end
         default: ;
      endcase
   end

   // NOTE: storage has no reset; only pointers and count define validity, so stale data is never observed.
   always_ff @(posedge clock) begin
      if (push && !cancel) mem_q[wr_ptr_q] <= in_value;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_value_q <= '0;
         out_put_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else if (cancel) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         out_put_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);

         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  state_q     <= S_LOAD;
                  out_value_q <= mem_q[rd_ptr_q];
                  out_put_q   <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_LOAD: begin
               state_q   <= S_WAIT;
               out_put_q <= 1'b0;
            end
            S_WAIT: begin
               if (pop) begin
                  state_q     <= S_LOAD;
                  out_value_q <= mem_q[rd_ptr_q];
                  out_put_q   <= 1'b1;
               end else if (rearm) begin
                  state_q   <= S_LOAD;
                  out_put_q <= 1'b1;
               end else if (done) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_value = out_value_q;
   assign out_put   = out_put_q;
   assign busy      = busy_q;
   assign count     = count_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed self-checking bench for timer_sched; covers the repeat feature when TIMER_SCHED_REPEAT_EN is defined.
module tb_timer_sched;

   localparam int W     = 8;
   localparam int DEPTH = 4;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic [W-1:0]          in_value = '0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  cancel = 1'b0;
   logic                  done = 1'b0;
`ifdef TIMER_SCHED_REPEAT_EN
   logic                  repeat_en = 1'b0;
`endif
   logic [W-1:0]          out_value;
   logic                  out_put;
   logic                  busy;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_pass   = 0;

   timer_sched #(.W(W), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_value  (in_value),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cancel    (cancel),
      .done      (done),
`ifdef TIMER_SCHED_REPEAT_EN
      .repeat_en (repeat_en),
`endif
      .out_value (out_value),
      .out_put   (out_put),
      .busy      (busy),
      .count     (count)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one active edge and settle away from it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset values
      #2;
      check("rst_out_value", 32'(out_value), 32'h00);
      check("rst_out_put",   32'(out_put),   0);
      check("rst_busy",      32'(busy),      0);
      check("rst_count",     32'(count),     0);
      check("rst_in_ready",  32'(in_ready),  1);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      // Single issue: push at edge N, put high N+1..N+2
      in_value = 8'h19; in_valid = 1'b1;
      tick();
      check("t1_count_after_push", 32'(count), 1);
      check("t1_put_not_yet",      32'(out_put), 0);
      in_valid = 1'b0;
      tick();
      check("t1_put_high",   32'(out_put),   1);
      check("t1_out_value",  32'(out_value), 32'h19);
      check("t1_busy_load",  32'(busy),      1);
      check("t1_count_pop",  32'(count),     0);
      tick();
      check("t1_put_low",    32'(out_put),   0);
      check("t1_busy_wait",  32'(busy),      1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t1_busy_idle",  32'(busy),      0);

      // Three back-to-back pushes while idle
      in_valid = 1'b1; in_value = 8'h05;
      tick();
      in_value = 8'h07;
      tick();
      check("t2_put_05",     32'(out_put),   1);
      check("t2_value_05",   32'(out_value), 32'h05);
      in_value = 8'h09;
      tick();
      in_valid = 1'b0;
      check("t2_count_2",    32'(count),     2);
      check("t2_put_low",    32'(out_put),   0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t2_put_07",     32'(out_put),   1);
      check("t2_value_07",   32'(out_value), 32'h07);
      check("t2_count_1",    32'(count),     1);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t2_value_09",   32'(out_value), 32'h09);
      check("t2_put_09",     32'(out_put),   1);
      check("t2_count_0",    32'(count),     0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t2_busy_idle",  32'(busy),      0);
      check("t2_count_end",  32'(count),     0);

      // done in IDLE is ignored
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t5_idle_busy",  32'(busy),      0);
      check("t5_idle_put",   32'(out_put),   0);
      check("t5_idle_value", 32'(out_value), 32'h09);

      // done during LOAD is ignored and does not pop
      in_valid = 1'b1; in_value = 8'h33;
      tick();
      in_value = 8'h44;
      tick();
      in_valid = 1'b0;
      check("t5_load_put",   32'(out_put),   1);
      check("t5_load_value", 32'(out_value), 32'h33);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t5_load_nopop", 32'(count),     1);
      check("t5_load_put0",  32'(out_put),   0);
      check("t5_load_value2",32'(out_value), 32'h33);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t5_issue_44",   32'(out_value), 32'h44);
      check("t5_issue_put",  32'(out_put),   1);
      tick();

      // Fill the FIFO while waiting
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_value = 8'hA1 + 8'(i);
         tick();
      end
      check("t3_count_full", 32'(count),     4);
      check("t3_ready_low",  32'(in_ready),  0);
      in_value = 8'hA5;
      tick();
      check("t3_no_push",    32'(count),     4);
      done = 1'b1;
      tick();
      done = 1'b0; in_valid = 1'b0;
      check("t3_pop_value",  32'(out_value), 32'hA1);
      check("t3_pop_count",  32'(count),     3);
      check("t3_ready_high", 32'(in_ready),  1);
      tick();

      // Cancel in WAIT with a simultaneous push
      cancel = 1'b1; in_valid = 1'b1; in_value = 8'hBB;
      tick();
      cancel = 1'b0; in_valid = 1'b0;
      check("t4_busy",       32'(busy),      0);
      check("t4_count",      32'(count),     0);
      check("t4_put",        32'(out_put),   0);
      check("t4_value_held", 32'(out_value), 32'hA1);
      tick();
      check("t4_no_issue",   32'(out_put),   0);
      in_valid = 1'b1; in_value = 8'hCC;
      tick();
      in_valid = 1'b0;
      tick();
      check("t4_after_flush",32'(out_value), 32'hCC);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t4_idle_again", 32'(busy),      0);

`ifdef TIMER_SCHED_REPEAT_EN
      repeat_en = 1'b1;
      in_valid = 1'b1; in_value = 8'h10;
      tick();
      in_valid = 1'b0;
      tick();
      check("rp_first_put",  32'(out_put),   1);
      tick();
      for (int i = 0; i < 3; i++) begin
         done = 1'b1;
         tick();
         done = 1'b0;
         check($sformatf("rp_put_%0d", i),   32'(out_put),   1);
         check($sformatf("rp_value_%0d", i), 32'(out_value), 32'h10);
         check($sformatf("rp_count_%0d", i), 32'(count),     0);
         tick();
      end
      repeat_en = 1'b0;
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rp_idle_busy",  32'(busy),      0);
      check("rp_idle_put",   32'(out_put),   0);
`endif

      // Asynchronous reset mid-operation
      in_valid = 1'b1; in_value = 8'h55;
      tick();
      in_value = 8'h66;
      tick();
      in_valid = 1'b0;
      check("ar_put_before", 32'(out_put),   1);
      #2;
      reset = 1'b0;
      #1;
      check("ar_put",        32'(out_put),   0);
      check("ar_value",      32'(out_value), 32'h00);
      check("ar_busy",       32'(busy),      0);
      check("ar_count",      32'(count),     0);
      check("ar_ready",      32'(in_ready),  1);
      @(negedge clock);
      reset = 1'b1;
      tick();
      check("ar_stays_idle", 32'(busy),      0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
